// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state and iterative-unit mode for the multi-cycle ALU.
package alu_pkg;

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_NOR  = 4'b1100;
   localparam logic [3:0] OP_MUL  = 4'b1000;
   localparam logic [3:0] OP_DIVU = 4'b1001;
   localparam logic [3:0] OP_REMU = 4'b1010;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   typedef enum logic [1:0] {MODE_MUL, MODE_DIV, MODE_REM} modo_t;

   function automatic logic is_iterativo(input logic [3:0] op);
      return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
   endfunction

   function automatic modo_t modo_de(input logic [3:0] op);
      case (op)
         OP_DIVU: return MODE_DIV;
         OP_REMU: return MODE_REM;
         default: return MODE_MUL;
      endcase
   endfunction

endpackage

// File: rtl/alu_multiciclo_if.sv
// Request/response bus of the multi-cycle ALU.
// A request transfers on a rising edge with in_valid & in_ready; a result transfers
// on a rising edge with out_valid & out_ready. Senders hold data stable until transfer.
interface alu_multiciclo_if #(parameter int WIDTH = 32) ();
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       ALUcontrol;
   logic [WIDTH-1:0] entrada1;
   logic [WIDTH-1:0] entrada2;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] saida;
   logic             Zero;
   logic             Negativo;
   logic             Overflow;
   logic             Invalido;

   modport master (
      output in_valid, ALUcontrol, entrada1, entrada2, out_ready,
      input  in_ready, out_valid, saida, Zero, Negativo, Overflow, Invalido
   );

   modport slave (
      input  in_valid, ALUcontrol, entrada1, entrada2, out_ready,
      output in_ready, out_valid, saida, Zero, Negativo, Overflow, Invalido
   );
endinterface

// File: rtl/alu_iterativo.sv
// Shift-add multiplier and restoring divider, one bit per clock.
// The first step is taken on the start edge itself, so the unit finishes WIDTH-1 edges later.
module alu_iterativo
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  modo_t            modo,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] resultado
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] STEPS = CW'(WIDTH);

   // acc: product or partial remainder; ra: multiplicand or quotient; rb: multiplier or divisor
   logic [WIDTH-1:0] acc, ra, rb;
   modo_t            modo_r;
   logic [CW-1:0]    count;

   logic [WIDTH-1:0] cur_acc, cur_ra, cur_rb;
   logic [WIDTH-1:0] nxt_acc, nxt_ra, nxt_rb;
   modo_t            cur_modo;
   logic [WIDTH:0]   shifted, trial;

   always_comb begin
      cur_acc  = start ? '0   : acc;
      cur_ra   = start ? a    : ra;
      cur_rb   = start ? b    : rb;
      cur_modo = start ? modo : modo_r;
      nxt_acc  = cur_acc;
      nxt_ra   = cur_ra;
      nxt_rb   = cur_rb;
      shifted  = {cur_acc, cur_ra[WIDTH-1]};
      trial    = shifted - {1'b0, cur_rb};
      if (cur_modo == MODE_MUL) begin
         if (cur_rb[0]) nxt_acc = cur_acc + cur_ra;
         nxt_ra = cur_ra << 1;
         nxt_rb = cur_rb >> 1;
      end else if (!trial[WIDTH]) begin
         nxt_acc = trial[WIDTH-1:0];
         nxt_ra  = {cur_ra[WIDTH-2:0], 1'b1};
      end else begin
         nxt_acc = shifted[WIDTH-1:0];
         nxt_ra  = {cur_ra[WIDTH-2:0], 1'b0};
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         acc    <= '0;
         ra     <= '0;
         rb     <= '0;
         modo_r <= MODE_MUL;
         count  <= '0;
         busy   <= 1'b0;
      end else if (start) begin
         acc    <= nxt_acc;
         ra     <= nxt_ra;
         rb     <= nxt_rb;
         modo_r <= modo;
         count  <= CW'(1);
         busy   <= 1'b1;
      end else if (busy) begin
         if (count == STEPS) begin
            busy <= 1'b0;
         end else begin
            acc   <= nxt_acc;
            ra    <= nxt_ra;
            rb    <= nxt_rb;
            count <= count + CW'(1);
         end
      end
   end

   assign done      = busy && (count == STEPS);
   assign resultado = (modo_r == MODE_DIV) ? ra : acc;

endmodule

// File: rtl/alu_multiciclo.sv
// Multi-cycle ALU: handshake FSM, single-cycle operations, flag generation and
// output registers; MUL/DIVU/REMU are delegated to alu_iterativo.
module alu_multiciclo
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic              clock,
   input  logic              reset_n,
   alu_multiciclo_if.slave   bus,
   output state_t            state_dbg
);

   state_t state, nxt_state;

   logic             accept, iter_op, it_done, it_busy;
   logic [WIDTH-1:0] it_res;
   logic [WIDTH-1:0] a, b, sum, dif;
   logic [WIDTH-1:0] s_res;
   logic             s_ovf, s_inv;

   logic [WIDTH-1:0] saida_r;
   logic             zero_r, neg_r, ovf_r, inv_r;

   assign a       = bus.entrada1;
   assign b       = bus.entrada2;
   assign accept  = bus.in_valid && (state == IDLE);
   assign iter_op = is_iterativo(bus.ALUcontrol);

   alu_iterativo #(.WIDTH(WIDTH)) u_iter (
      .clock     (clock),
      .reset_n   (reset_n),
      .start     (accept && iter_op),
      .modo      (modo_de(bus.ALUcontrol)),
      .a         (a),
      .b         (b),
      .busy      (it_busy),
      .done      (it_done),
      .resultado (it_res)
   );

   assign sum = a + b;
   assign dif = a - b;

   always_comb begin
      s_res = '0;
      s_ovf = 1'b0;
      s_inv = 1'b0;
      case (bus.ALUcontrol)
         OP_AND: s_res = a & b;
         OP_OR:  s_res = a | b;
         OP_NOR: s_res = ~(a | b);
         OP_ADD: begin
            s_res = sum;
            s_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         // For SUB the B sign is inverted before the same-sign test
         OP_SUB: begin
            s_res = dif;
            s_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SLT: s_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_MUL, OP_DIVU, OP_REMU: s_res = '0;
         default: s_inv = 1'b1;
      endcase
   end

   always_comb begin
      nxt_state = state;
      case (state)
         IDLE: if (accept) nxt_state = iter_op ? CALC : DONE;
         CALC: if (it_done) nxt_state = DONE;
         DONE: if (bus.out_ready) nxt_state = IDLE;
         default: nxt_state = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= nxt_state;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         saida_r <= '0;
         zero_r  <= 1'b1;
         neg_r   <= 1'b0;
         ovf_r   <= 1'b0;
         inv_r   <= 1'b0;
      end else if (accept && !iter_op) begin
         saida_r <= s_res;
         zero_r  <= (s_res == '0);
         neg_r   <= s_res[WIDTH-1];
         ovf_r   <= s_ovf;
         inv_r   <= s_inv;
      end else if (state == CALC && it_done) begin
         saida_r <= it_res;
         zero_r  <= (it_res == '0);
         neg_r   <= it_res[WIDTH-1];
         ovf_r   <= 1'b0;
         inv_r   <= 1'b0;
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.saida     = saida_r;
   assign bus.Zero      = zero_r;
   assign bus.Negativo  = neg_r;
   assign bus.Overflow  = ovf_r;
   assign bus.Invalido  = inv_r;
   assign state_dbg     = state;

endmodule

// File: tb/tb_alu_multiciclo.sv
// Directed bench for alu_multiciclo with an arithmetic reference model and scoreboard.
module tb_alu_multiciclo;
   import alu_pkg::*;

   localparam int W = 32;

   logic   clock = 1'b0;
   logic   reset_n = 1'b0;
   state_t state_dbg;
   int     tests = 0;
   int     fails = 0;

   // Expected entries packed as {Invalido, Overflow, Negativo, Zero, saida}
   logic [W+3:0] exp_q[$];

   logic [W-1:0] last_saida;
   logic         last_zero, last_neg, last_ovf, last_inv;

   alu_multiciclo_if #(.WIDTH(W)) bus ();

   alu_multiciclo #(.WIDTH(W)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .bus       (bus.slave),
      .state_dbg (state_dbg)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [W+3:0] got, input logic [W+3:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   function automatic logic [W+3:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
      logic [W-1:0] r;
      logic         ovf, inv;
      longint       sr;
      logic [63:0]  p;
      r = '0; ovf = 1'b0; inv = 1'b0;
      case (op)
         4'b0000: r = a & b;
         4'b0001: r = a | b;
         4'b1100: r = ~(a | b);
         4'b0010: begin
            sr  = longint'($signed(a)) + longint'($signed(b));
            r   = a + b;
            ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
         end
         4'b0110: begin
            sr  = longint'($signed(a)) - longint'($signed(b));
            r   = a - b;
            ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
         end
         4'b0111: r = ($signed(a) < $signed(b)) ? 1 : 0;
         4'b1000: begin
            p = {32'b0, a} * {32'b0, b};
            r = p[W-1:0];
         end
         4'b1001: r = (b == 0) ? '1 : a / b;
         4'b1010: r = (b == 0) ? a : a % b;
         default: inv = 1'b1;
      endcase
      return {inv, ovf, r[W-1], (r == 0), r};
   endfunction

   function automatic logic [W+3:0] outs();
      return {bus.Invalido, bus.Overflow, bus.Negativo, bus.Zero, bus.saida};
   endfunction

   // Scoreboard: every cycle a result is presented it must match the queue head
   always @(negedge clock) begin
      if (reset_n && bus.out_valid) begin
         chk("in_ready_while_valid", {34'b0, bus.in_ready}, '0);
         if (exp_q.size() == 0) begin
            chk("spurious_out_valid", {34'b0, bus.out_valid}, '0);
         end else begin
            chk("result", outs(), exp_q[0]);
            if (bus.out_ready) void'(exp_q.pop_front());
         end
      end
   end

   task automatic run_op(input string name, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int hold);
      int lat, guard, exp_lat;
      logic [W+3:0] snap;
      exp_lat = is_iterativo(op) ? W + 1 : 1;
      guard = 0;
      while (!bus.in_ready && guard < 100) begin
         @(posedge clock); #1; guard++;
      end
      chk({name, "_in_ready"}, {34'b0, bus.in_ready}, 36'd1);
      bus.in_valid   = 1'b1;
      bus.ALUcontrol = op;
      bus.entrada1   = a;
      bus.entrada2   = b;
      exp_q.push_back(model(op, a, b));
      @(posedge clock); #1;
      bus.in_valid   = 1'b0;
      bus.ALUcontrol = 4'($urandom_range(0, 15));
      bus.entrada1   = $urandom;
      bus.entrada2   = $urandom;
      lat = 1;
      while (!bus.out_valid && lat < 200) begin
         @(posedge clock); #1; lat++;
      end
      chk({name, "_latency"}, 36'(lat), 36'(exp_lat));
      snap = outs();
      {last_inv, last_ovf, last_neg, last_zero, last_saida} = snap;
      for (int i = 0; i < hold; i++) begin
         @(posedge clock); #1;
         chk({name, "_hold"}, {bus.out_valid, bus.in_ready, outs()},
             {1'b1, 1'b0, snap});
      end
      bus.out_ready = 1'b1;
      @(posedge clock); #1;
      bus.out_ready = 1'b0;
      chk({name, "_release"}, {34'b0, bus.in_ready, bus.out_valid}, 36'b10);
   endtask

   initial begin
      int seen;
      bus.in_valid   = 1'b0;
      bus.out_ready  = 1'b0;
      bus.ALUcontrol = '0;
      bus.entrada1   = '0;
      bus.entrada2   = '0;
      repeat (2) @(posedge clock);
      #1;
      chk("reset_outputs", {bus.in_ready, bus.out_valid, outs()},
          {1'b1, 1'b0, 4'b0001, 32'h0});
      reset_n = 1'b1;
      @(posedge clock); #1;

      run_op("sub_eq", OP_SUB, 32'd5, 32'd5, 0);
      chk("sub_eq_lit", {last_zero, last_saida}, {1'b1, 32'h0});

      run_op("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'h1, 0);
      chk("add_ovf_lit", {last_ovf, last_neg, last_zero, last_saida},
          {3'b110, 32'h8000_0000});

      run_op("slt_neg", OP_SLT, 32'hFFFF_FFFF, 32'h1, 0);
      chk("slt_neg_lit", last_saida, 32'h1);
      run_op("slt_pos", OP_SLT, 32'h1, 32'hFFFF_FFFF, 0);
      run_op("sub_ovf", OP_SUB, 32'h8000_0000, 32'h1, 0);
      chk("sub_ovf_lit", {last_ovf, last_saida}, {1'b1, 32'h7FFF_FFFF});
      run_op("and", OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 0);
      run_op("or", OP_OR, 32'hA000_0001, 32'h0500_0010, 0);
      run_op("nor", OP_NOR, 32'h0000_FFFF, 32'h00FF_0000, 0);

      run_op("mul", OP_MUL, 32'h0000_FFFF, 32'h0001_0001, 0);
      chk("mul_lit", last_saida, 32'hFFFF_FFFF);
      run_op("mul_wrap", OP_MUL, 32'h1234_5678, 32'h9ABC_DEF1, 0);
      run_op("divu", OP_DIVU, 32'd100, 32'd7, 0);
      chk("divu_lit", last_saida, 32'd14);
      run_op("remu", OP_REMU, 32'd100, 32'd7, 0);
      chk("remu_lit", last_saida, 32'd2);
      run_op("divu_big", OP_DIVU, 32'hFFFF_FFFE, 32'h0000_0003, 0);
      run_op("divu_zero", OP_DIVU, 32'd9, 32'd0, 0);
      chk("divu_zero_lit", {last_inv, last_saida}, {1'b0, 32'hFFFF_FFFF});
      run_op("remu_zero", OP_REMU, 32'd9, 32'd0, 0);
      chk("remu_zero_lit", {last_inv, last_saida}, {1'b0, 32'd9});

      run_op("backpressure", OP_ADD, 32'h0000_1000, 32'h0000_0234, 5);
      chk("backpressure_lit", last_saida, 32'h0000_1234);
      run_op("invalid", 4'b0011, 32'h1111_1111, 32'h2222_2222, 0);
      chk("invalid_lit", {last_inv, last_zero, last_saida}, {2'b11, 32'h0});

      // Abort a multiply ten cycles in: nothing may come out afterwards
      bus.in_valid   = 1'b1;
      bus.ALUcontrol = OP_MUL;
      bus.entrada1   = 32'h0000_0003;
      bus.entrada2   = 32'h0000_0005;
      @(posedge clock); #1;
      bus.in_valid = 1'b0;
      repeat (9) @(posedge clock);
      #2;
      reset_n = 1'b0;
      #1;
      chk("abort_outputs", {bus.in_ready, bus.out_valid, outs()},
          {1'b1, 1'b0, 4'b0001, 32'h0});
      @(posedge clock); #1;
      reset_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 2 * W; i++) begin
         @(posedge clock); #1;
         if (bus.out_valid) seen++;
      end
      chk("abort_no_result", 36'(seen), 36'd0);
      chk("abort_idle", {35'b0, bus.in_ready}, 36'd1);

      run_op("after_abort", OP_ADD, 32'd40, 32'd2, 0);
      chk("after_abort_lit", last_saida, 32'd42);
      chk("queue_drained", 36'(exp_q.size()), 36'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
